// File: rtl/ll_multi_queue_if.sv
// ll_multi_queue_if: request and status bundle for the shared-pool multi-queue
interface ll_multi_queue_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2048,
    parameter int FIFOS = 4
);
    localparam int LOG2_FIFOS = $clog2(FIFOS);
    localparam int LOG2_DEPTH = $clog2(DEPTH);
    logic                              i_push;
    logic [LOG2_FIFOS-1:0]             i_push_fifo;
    logic [WIDTH-1:0]                  i_d;
    logic                              i_pop;
    logic [LOG2_FIFOS-1:0]             i_pop_fifo;
    logic                              i_flush;
    logic [LOG2_FIFOS-1:0]             i_flush_fifo;
    logic                              o_ready;
    logic [WIDTH-1:0]                  o_q;
    logic                              o_q_valid;
    logic [LOG2_FIFOS-1:0]             o_q_fifo;
    logic [FIFOS-1:0]                  o_empty;
    logic [(LOG2_DEPTH+1)*FIFOS-1:0]   o_count;
    logic                              o_full;
    logic                              o_almost_full;
    logic [LOG2_DEPTH:0]               o_free_count;
    logic                              o_overflow;
    logic                              o_underflow;
    modport master (
        output i_push, i_push_fifo, i_d, i_pop, i_pop_fifo, i_flush, i_flush_fifo,
        input  o_ready, o_q, o_q_valid, o_q_fifo, o_empty, o_count, o_full,
               o_almost_full, o_free_count, o_overflow, o_underflow
    );
    modport slave (
        input  i_push, i_push_fifo, i_d, i_pop, i_pop_fifo, i_flush, i_flush_fifo,
        output o_ready, o_q, o_q_valid, o_q_fifo, o_empty, o_count, o_full,
               o_almost_full, o_free_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/ll_multi_queue.sv
// ll_multi_queue: several FIFOs sharing one linked-list node pool with a free list
module ll_multi_queue #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 2048,
    parameter int FIFOS     = 4,
    parameter int AF_THRESH = 2
) (
    input logic             clk,
    input logic             rst,
    ll_multi_queue_if.slave bus
);
    localparam int LOG2_FIFOS = $clog2(FIFOS);
    localparam int LOG2_DEPTH = $clog2(DEPTH);
    localparam int CW = LOG2_DEPTH + 1;
    localparam logic [1:0] S_INIT = 2'd0, S_IDLE = 2'd1, S_FLUSH = 2'd2;

    logic [1:0]            r_state;
    logic [LOG2_DEPTH-1:0] r_init_idx;
    logic [LOG2_DEPTH-1:0] r_free_head;
    logic [CW-1:0]         r_free_cnt;
    logic [LOG2_DEPTH-1:0] r_head [FIFOS];
    logic [LOG2_DEPTH-1:0] r_tail [FIFOS];
    logic [CW-1:0]         r_cnt  [FIFOS];
    logic [WIDTH-1:0]      r_dat  [DEPTH];
    logic [LOG2_DEPTH-1:0] r_link [DEPTH];
    logic [WIDTH-1:0]      r_q;
    logic                  r_q_valid;
    logic [LOG2_FIFOS-1:0] r_q_fifo;
    logic                  r_ovf;
    logic                  r_unf;

    logic                  w_ready, w_full, w_flush, w_fl_busy, w_push, w_pop;
    logic                  w_push_drop, w_pop_empty;
    logic [LOG2_DEPTH-1:0] w_push_tail, w_pop_head, w_fl_head, w_fl_tail, w_fh_next;
    logic [FIFOS-1:0]      w_empty, w_push_sel, w_pop_sel, w_fl_sel;

    assign w_ready     = r_state == S_IDLE;
    assign w_full      = r_free_cnt == '0;
    assign w_flush     = w_ready & bus.i_flush;
    assign w_fl_busy   = ~w_empty[bus.i_flush_fifo];
    assign w_push      = w_ready & bus.i_push & ~bus.i_flush & ~w_full;
    assign w_pop       = w_ready & bus.i_pop & ~bus.i_flush & ~w_empty[bus.i_pop_fifo];
    assign w_push_drop = w_ready & bus.i_push & ~bus.i_flush & w_full;
    assign w_pop_empty = w_ready & bus.i_pop & ~bus.i_flush & w_empty[bus.i_pop_fifo];
    assign w_push_tail = r_tail[bus.i_push_fifo];
    assign w_pop_head  = r_head[bus.i_pop_fifo];
    assign w_fl_head   = r_head[bus.i_flush_fifo];
    assign w_fl_tail   = r_tail[bus.i_flush_fifo];
    assign w_fh_next   = r_link[r_free_head];

    for (genvar g = 0; g < FIFOS; g++) begin : g_q
        assign w_empty[g]    = r_cnt[g] == '0;
        assign w_push_sel[g] = w_push & (bus.i_push_fifo == LOG2_FIFOS'(g));
        assign w_pop_sel[g]  = w_pop & (bus.i_pop_fifo == LOG2_FIFOS'(g));
        assign w_fl_sel[g]   = w_flush & (bus.i_flush_fifo == LOG2_FIFOS'(g));
        assign bus.o_count[(g+1)*CW-1 -: CW] = r_cnt[g];
    end

    assign bus.o_ready       = w_ready;
    assign bus.o_q           = r_q;
    assign bus.o_q_valid     = r_q_valid;
    assign bus.o_q_fifo      = r_q_fifo;
    assign bus.o_empty       = w_empty;
    assign bus.o_full        = w_full;
    assign bus.o_almost_full = r_free_cnt < CW'(AF_THRESH);
    assign bus.o_free_count  = r_free_cnt;
    assign bus.o_overflow    = r_ovf;
    assign bus.o_underflow   = r_unf;

    // control FSM, free-list head, per-queue pointers/counters and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_INIT;
            r_init_idx  <= '0;
            r_free_head <= LOG2_DEPTH'(FIFOS);
            r_free_cnt  <= CW'(DEPTH - FIFOS);
            r_q         <= '0;
            r_q_valid   <= 1'b0;
            r_q_fifo    <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            for (int i = 0; i < FIFOS; i++) begin
                r_head[i] <= LOG2_DEPTH'(i);
                r_tail[i] <= LOG2_DEPTH'(i);
                r_cnt[i]  <= '0;
            end
        end else begin
            r_state    <= r_state == S_INIT ? (r_init_idx == LOG2_DEPTH'(DEPTH - 1) ? S_IDLE : S_INIT) :
                          r_state == S_IDLE && w_flush ? S_FLUSH : S_IDLE;
            r_init_idx <= r_init_idx + LOG2_DEPTH'(r_state == S_INIT);
            r_q_valid  <= w_pop;
            r_ovf      <= r_ovf | w_push_drop;
            r_unf      <= r_unf | w_pop_empty;
            if (w_pop) begin
                r_q      <= r_dat[w_pop_head];
                r_q_fifo <= bus.i_pop_fifo;
            end
            if (w_flush) begin
                if (w_fl_busy) begin
                    r_free_head <= r_link[w_fl_head];
                    r_free_cnt  <= r_free_cnt + r_cnt[bus.i_flush_fifo];
                end
            end else begin
                r_free_head <= w_pop ? w_pop_head : w_push ? w_fh_next : r_free_head;
                r_free_cnt  <= r_free_cnt + CW'(w_pop) - CW'(w_push);
            end
            for (int i = 0; i < FIFOS; i++) begin
                if (w_fl_sel[i]) begin
                    r_tail[i] <= r_head[i];
                    r_cnt[i]  <= '0;
                end else begin
                    if (w_pop_sel[i]) r_head[i] <= r_link[r_head[i]];
                    if (w_push_sel[i]) r_tail[i] <= r_free_head;
                    r_cnt[i] <= r_cnt[i] + CW'(w_push_sel[i]) - CW'(w_pop_sel[i]);
                end
            end
        end
    end

    // node RAMs: link chain init, tail fill on push, node return on pop, chain splice on flush
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) r_link[r_init_idx] <= r_init_idx + LOG2_DEPTH'(1);
        if (w_flush && w_fl_busy) r_link[w_fl_tail] <= r_free_head;
        if (w_push) begin
            r_link[w_push_tail] <= r_free_head;
            r_dat[w_push_tail]  <= bus.i_d;
        end
        if (w_pop) r_link[w_pop_head] <= w_push ? w_fh_next : r_free_head;
    end
endmodule
